// File: rtl/exec_core.sv
// Register file plus ALU execute stage: single-cycle ALU ops retire at the
// accepting edge, MUL/DIVU/REMU iterate one bit per cycle behind a start/busy/done handshake.
module exec_core #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int ALUctrl_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ALUctrl_WIDTH-1:0] ALUctrl,
  input  logic                     ALUsrc,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  input  logic                     RegWrite,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     busy,
  output logic                     done,
  output logic                     EQ,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int NREG = 1 << ADDRESS_WIDTH;
  localparam int SHW  = $clog2(DATA_WIDTH);

  localparam logic [ALUctrl_WIDTH-1:0] OP_ADD  = ALUctrl_WIDTH'(0);
  localparam logic [ALUctrl_WIDTH-1:0] OP_SUB  = ALUctrl_WIDTH'(1);
  localparam logic [ALUctrl_WIDTH-1:0] OP_AND  = ALUctrl_WIDTH'(2);
  localparam logic [ALUctrl_WIDTH-1:0] OP_OR   = ALUctrl_WIDTH'(3);
  localparam logic [ALUctrl_WIDTH-1:0] OP_XOR  = ALUctrl_WIDTH'(4);
  localparam logic [ALUctrl_WIDTH-1:0] OP_SLL  = ALUctrl_WIDTH'(5);
  localparam logic [ALUctrl_WIDTH-1:0] OP_SRL  = ALUctrl_WIDTH'(6);
  localparam logic [ALUctrl_WIDTH-1:0] OP_SLT  = ALUctrl_WIDTH'(7);
  localparam logic [ALUctrl_WIDTH-1:0] OP_MUL  = ALUctrl_WIDTH'(8);
  localparam logic [ALUctrl_WIDTH-1:0] OP_DIVU = ALUctrl_WIDTH'(9);
  localparam logic [ALUctrl_WIDTH-1:0] OP_REMU = ALUctrl_WIDTH'(10);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                     state, state_nx;
  logic [DATA_WIDTH-1:0]      regs [NREG];
  logic [DATA_WIDTH-1:0]      op1, op2, alu_res;
  logic                       is_multi, is_single;
  logic                       accept_single, accept_multi, last;
  logic [SHW-1:0]             cnt;
  logic                       vld_p1;

  logic [ALUctrl_WIDTH-1:0]   op_p1;
  logic [ADDRESS_WIDTH-1:0]   rd_p1;
  logic                       wr_p1;
  logic [DATA_WIDTH-1:0]      acc_p1, opa_p1, opb_p1;
  logic [DATA_WIDTH-1:0]      acc_nx, opa_nx, opb_nx, mc_res;
  logic [DATA_WIDTH:0]        shifted, diff;

  logic                       wr_en;
  logic [ADDRESS_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]      wr_data;

  function automatic logic [DATA_WIDTH-1:0] alu_single(
    input logic [ALUctrl_WIDTH-1:0] op,
    input logic [DATA_WIDTH-1:0]    a,
    input logic [DATA_WIDTH-1:0]    b
  );
    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic [DATA_WIDTH-1:0]        r;
    a_s = a;
    b_s = b;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[SHW-1:0];
      OP_SRL:  r = a >> b[SHW-1:0];
      OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Operand fetch: x0 is forced to zero regardless of array contents.
  always_comb begin
    op1 = (rs1 == '0) ? '0 : regs[rs1];
    op2 = ALUsrc ? ImmOp : ((rs2 == '0) ? '0 : regs[rs2]);
  end

  assign EQ        = (op1 == op2);
  assign a0        = regs[ADDRESS_WIDTH'(10)];
  assign alu_res   = alu_single(ALUctrl, op1, op2);
  assign is_multi  = (ALUctrl == OP_MUL) || (ALUctrl == OP_DIVU) || (ALUctrl == OP_REMU);
  assign is_single = (ALUctrl <= OP_SLT);
  assign done      = vld_p1;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && is_multi) state_nx = RUN;
      RUN:     if (cnt == '0)         state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy          = (state == RUN);
    accept_single = (state == IDLE) && start && !is_multi;
    accept_multi  = (state == IDLE) && start && is_multi;
    last          = (state == RUN) && (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept_single || last;
      if (accept_multi)       cnt <= SHW'(DATA_WIDTH - 1);
      else if (state == RUN)  cnt <= cnt - 1'b1;
    end
  end

  // One iteration: shift-add for MUL, restoring step for DIVU/REMU.
  // A zero divisor never fails the trial subtract, giving all-ones quotient
  // and the dividend as remainder without a special case.
  always_comb begin
    acc_nx  = acc_p1;
    opa_nx  = opa_p1;
    opb_nx  = opb_p1;
    shifted = {acc_p1, opa_p1[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, opb_p1};
    if (op_p1 == OP_MUL) begin
      acc_nx = opb_p1[0] ? (acc_p1 + opa_p1) : acc_p1;
      opa_nx = opa_p1 << 1;
      opb_nx = opb_p1 >> 1;
    end else if (!diff[DATA_WIDTH]) begin
      acc_nx = diff[DATA_WIDTH-1:0];
      opa_nx = {opa_p1[DATA_WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = shifted[DATA_WIDTH-1:0];
      opa_nx = {opa_p1[DATA_WIDTH-2:0], 1'b0};
    end
    mc_res = (op_p1 == OP_DIVU) ? opa_nx : acc_nx;
  end

  // Latch stage: operands captured on accept, then iterated each RUN cycle
  always_ff @(posedge clk) begin
    if (accept_multi) begin
      acc_p1 <= '0;
      opa_p1 <= op1;
      opb_p1 <= op2;
      op_p1  <= ALUctrl;
      rd_p1  <= rd;
      wr_p1  <= RegWrite;
    end else if (state == RUN) begin
      acc_p1 <= acc_nx;
      opa_p1 <= opa_nx;
      opb_p1 <= opb_nx;
    end
  end

  // Single write port shared between immediate retire and iterative writeback
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd;
    wr_data = alu_res;
    if (last) begin
      wr_en   = wr_p1 && (rd_p1 != '0);
      wr_addr = rd_p1;
      wr_data = mc_res;
    end else if (accept_single && is_single) begin
      wr_en   = RegWrite && (rd != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule
